// File: rtl/mpu_pkg.sv
// Shared types and parameter defaults for the MPU matrix bank.
// Imported by mpu_rc_counter and mpu_matrix_bank.
package mpu_pkg;

    localparam int BANK_FP_DEF   = 32;
    localparam int BANK_M_DEF    = 4;
    localparam int BANK_N_DEF    = 4;
    localparam int BANK_REGS_DEF = 8;

    // Wide enough for any practical M/N.
    localparam int IDX_W = 8;

    typedef enum logic {
        L_IDLE,
        L_STREAM
    } load_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT
    } store_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
    } rc_idx_t;

    function automatic logic [IDX_W-1:0] idx_max(
        input logic [IDX_W-1:0] size
    );
        return size - IDX_W'(1);
    endfunction

endpackage

// File: rtl/mpu_rc_counter.sv
// Row-major (i,j) walker: j counts columns, i counts rows.
// wrap_o flags the final column, last_o the final row.
import mpu_pkg::*;

module mpu_rc_counter #(
    parameter int M = BANK_M_DEF,
    parameter int N = BANK_N_DEF,
    localparam int MBITS = $clog2(M),
    localparam int NBITS = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic [MBITS:0] m_i,
    input  logic [NBITS:0] n_i,
    output rc_idx_t        idx_o,
    output logic           wrap_o,
    output logic           last_o
);

    rc_idx_t idx_q;
    rc_idx_t idx_d;

    assign idx_o  = idx_q;
    assign wrap_o = (idx_q.j == idx_max(IDX_W'(n_i)));
    assign last_o = (idx_q.i == idx_max(IDX_W'(m_i)));

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (en_i && wrap_o) begin
            idx_d.j = '0;
            idx_d.i = last_o ? '0 : idx_q.i + IDX_W'(1);
        end else if (en_i) begin
            idx_d.j = idx_q.j + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/mpu_matrix_bank.sv
// Multi-register matrix store with streamed row-major load/drain.
// Define MPU_BANK_BOUNDS_CHECK_EN to reject illegal sizes / invalid stores.
import mpu_pkg::*;

module mpu_matrix_bank #(
    parameter int FP       = BANK_FP_DEF,
    parameter int M        = BANK_M_DEF,
    parameter int N        = BANK_N_DEF,
    parameter int NUM_REGS = BANK_REGS_DEF,
    localparam int RBITS = $clog2(NUM_REGS),
    localparam int MBITS = $clog2(M),
    localparam int NBITS = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_req_in,
    input  logic [RBITS-1:0]    load_addr_in,
    input  logic [MBITS:0]      load_m_in,
    input  logic [NBITS:0]      load_n_in,
    input  logic                load_valid_in,
    input  logic [FP-1:0]       load_element_in,
    output logic                load_ready_out,
    input  logic                store_req_in,
    input  logic [RBITS-1:0]    store_addr_in,
    output logic                store_valid_out,
    output logic [FP-1:0]       store_element_out,
    output logic                store_last_out,
    input  logic                store_ready_in,
    output logic [NUM_REGS-1:0] reg_valid_out,
    output logic                busy_out,
    output logic                err_out
);

    localparam int DEPTH = NUM_REGS * M * N;
    localparam int AW    = $clog2(DEPTH);

    load_state_t         lstate_q;
    store_state_t        sstate_q;
    logic [RBITS-1:0]    l_addr_q;
    logic [RBITS-1:0]    s_addr_q;
    logic [MBITS:0]      m_size_q [NUM_REGS];
    logic [NBITS:0]      n_size_q [NUM_REGS];
    logic [NUM_REGS-1:0] valid_q;
    logic [FP-1:0]       mem_q [DEPTH];

    rc_idx_t    l_idx;
    rc_idx_t    s_idx;
    logic       l_wrap;
    logic       l_last;
    logic       s_wrap;
    logic       s_last;
    logic       load_ok;
    logic       store_ok;
    logic       load_start;
    logic       store_start;
    logic       conflict;
    logic       l_wr;
    logic       l_end;
    logic       s_adv;
    logic       s_fin;
    logic       s_en;
    logic [AW-1:0] l_waddr;
    logic [AW-1:0] s_raddr;

`ifdef MPU_BANK_BOUNDS_CHECK_EN
    localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
    localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);

    assign load_ok  = (load_m_in != '0) && (load_m_in <= M_MAX)
                   && (load_n_in != '0) && (load_n_in <= N_MAX);
    assign store_ok = valid_q[store_addr_in];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_out <= 1'b0;
        end else begin
            err_out <= ((lstate_q == L_IDLE) && load_req_in && !load_ok)
                    || ((sstate_q == S_IDLE) && store_req_in && !store_ok);
        end
    end
`else
    assign load_ok  = 1'b1;
    assign store_ok = 1'b1;
    assign err_out  = 1'b0;
`endif

    assign load_start  = (lstate_q == L_IDLE) && load_req_in && load_ok;
    assign store_start = (sstate_q == S_IDLE) && store_req_in && store_ok;

    // A store must not overtake a load of the same register,
    // including one that is being requested in this very cycle.
    assign conflict = ((lstate_q == L_STREAM) && (store_addr_in == l_addr_q))
                   || (load_start && (store_addr_in == load_addr_in));

    assign l_wr  = (lstate_q == L_STREAM) && load_valid_in;
    assign l_end = l_wrap && l_last;
    assign s_adv = (sstate_q == S_STREAM) && (!store_valid_out || store_ready_in);
    assign s_fin = store_valid_out && store_last_out;
    assign s_en  = s_adv && !s_fin;

    assign l_waddr = AW'(int'(l_addr_q) * M * N + int'(l_idx.i) * N + int'(l_idx.j));
    assign s_raddr = AW'(int'(s_addr_q) * M * N + int'(s_idx.i) * N + int'(s_idx.j));

    assign reg_valid_out = valid_q;
    assign busy_out      = (lstate_q != L_IDLE) || (sstate_q != S_IDLE);

    mpu_rc_counter #(.M(M), .N(N)) u_load_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (lstate_q != L_STREAM),
        .en_i   (l_wr),
        .m_i    (m_size_q[l_addr_q]),
        .n_i    (n_size_q[l_addr_q]),
        .idx_o  (l_idx),
        .wrap_o (l_wrap),
        .last_o (l_last)
    );

    mpu_rc_counter #(.M(M), .N(N)) u_store_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (sstate_q != S_STREAM),
        .en_i   (s_en),
        .m_i    (m_size_q[s_addr_q]),
        .n_i    (n_size_q[s_addr_q]),
        .idx_o  (s_idx),
        .wrap_o (s_wrap),
        .last_o (s_last)
    );

    always_ff @(posedge clk) begin
        if (!rst && l_wr) begin
            mem_q[l_waddr] <= load_element_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lstate_q       <= L_IDLE;
            l_addr_q       <= '0;
            valid_q        <= '0;
            load_ready_out <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                m_size_q[r] <= '0;
                n_size_q[r] <= '0;
            end
        end else begin
            unique case (lstate_q)
                L_IDLE: begin
                    if (load_start) begin
                        l_addr_q                 <= load_addr_in;
                        m_size_q[load_addr_in]   <= load_m_in;
                        n_size_q[load_addr_in]   <= load_n_in;
                        valid_q[load_addr_in]    <= 1'b0;
                        load_ready_out           <= 1'b1;
                        lstate_q                 <= L_STREAM;
                    end
                end
                L_STREAM: begin
                    if (l_wr && l_end) begin
                        valid_q[l_addr_q] <= 1'b1;
                        load_ready_out    <= 1'b0;
                        lstate_q          <= L_IDLE;
                    end
                end
                default: lstate_q <= L_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sstate_q          <= S_IDLE;
            s_addr_q          <= '0;
            store_valid_out   <= 1'b0;
            store_element_out <= '0;
            store_last_out    <= 1'b0;
        end else begin
            unique case (sstate_q)
                S_IDLE: begin
                    if (store_start) begin
                        s_addr_q <= store_addr_in;
                        sstate_q <= conflict ? S_WAIT : S_STREAM;
                    end
                end
                S_WAIT: begin
                    if (lstate_q == L_IDLE) begin
                        sstate_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (s_adv && s_fin) begin
                        store_valid_out <= 1'b0;
                        store_last_out  <= 1'b0;
                        sstate_q        <= S_IDLE;
                    end else if (s_adv) begin
                        store_valid_out   <= 1'b1;
                        store_element_out <= mem_q[s_raddr];
                        store_last_out    <= s_wrap && s_last;
                    end
                end
                default: sstate_q <= S_IDLE;
            endcase
        end
    end

endmodule
